// File: rtl/bram_arbiter2.sv
// Purpose: round-robin arbiter giving two requesters shared access to one single-port 1024xDW BRAM.
// Latency: grant is combinational in the request cycle; read data returns one cycle after the grant.
// Backpressure: a requester holds its request until req_ready; at most one requester is accepted per cycle.
module bram_arbiter2 #(
    parameter int DW = 16,
    parameter int WL = 1024
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_we,
    input  logic [1:0][12:0]     req_addr,
    input  logic [1:0][DW-1:0]   req_wdata,
    output logic [1:0]           rsp_valid,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 rsp_err,
    output logic                 ram_EN,
    output logic [3:0]           ram_WE,
    output logic [12:0]          ram_A,
    output logic [DW-1:0]        ram_Di,
    input  logic [DW-1:0]        ram_Do
);

    localparam logic [11:0] WL_L = 12'(WL);

    // Read captured at the grant edge, answered in the following cycle.
    typedef struct packed {
        logic vld;
        logic owner;
        logic err;
    } pend_t;

    pend_t             pend_q;
    logic              last_q;     // requester served most recently
    logic [12:0]       a_q;        // address held while idle
    logic [DW-1:0]     di_q;       // write data held while idle
    logic              gnt_vld;
    logic              gnt_idx;
    logic              gnt_in_range;
    logic              rsp_act;

    // Pick the requester: a lone requester wins, contention goes to the one not served last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        if (RSTn) begin
            case (req_valid)
                2'b01:   begin gnt_vld = 1'b1; gnt_idx = 1'b0;    end
                2'b10:   begin gnt_vld = 1'b1; gnt_idx = 1'b1;    end
                2'b11:   begin gnt_vld = 1'b1; gnt_idx = ~last_q; end
                default: begin gnt_vld = 1'b0; gnt_idx = 1'b0;    end
            endcase
        end
    end

    // Drive the RAM and the response strobes; responses are suppressed while reset is asserted.
    always_comb begin
        gnt_in_range = ({1'b0, req_addr[gnt_idx][12:2]} < WL_L);
        rsp_act      = RSTn & pend_q.vld;
        req_ready[0] = gnt_vld & ~gnt_idx;
        req_ready[1] = gnt_vld & gnt_idx;
        ram_A        = gnt_vld ? req_addr[gnt_idx]  : a_q;
        ram_Di       = gnt_vld ? req_wdata[gnt_idx] : di_q;
        ram_WE       = (gnt_vld & req_we[gnt_idx] & gnt_in_range) ? 4'hF : 4'h0;
        // EN stays high in the response cycle because the RAM gates Do with the current EN.
        ram_EN       = (gnt_vld & gnt_in_range) | rsp_act;
        rsp_valid[0] = rsp_act & ~pend_q.owner;
        rsp_valid[1] = rsp_act & pend_q.owner;
        rsp_err      = rsp_act & pend_q.err;
        rsp_rdata    = (rsp_act & ~pend_q.err) ? ram_Do : '0;
    end

    // Round-robin pointer, pending-read capture and idle hold registers.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            last_q <= 1'b1;
            pend_q <= '0;
            a_q    <= '0;
            di_q   <= '0;
        end else begin
            pend_q.vld   <= gnt_vld & ~req_we[gnt_idx];
            pend_q.owner <= gnt_idx;
            pend_q.err   <= ~gnt_in_range;
            if (gnt_vld) begin
                last_q <= gnt_idx;
                a_q    <= ram_A;
                di_q   <= ram_Di;
            end
        end
    end

endmodule

// File: doc/bram_arbiter2.md
Name: bram_arbiter2

Overview:
- Two-requester arbiter sharing one single-port 1024x16 behavioural BRAM.
  - BRAM interface: byte address, word index = address>>2, 4-bit all-ones write enable, registered read address, read data gated by EN.
- Sequences accesses with round-robin fairness and returns read data one cycle after grant.
- Sits between the user-project bus slave (requester 0) and the accelerator/DMA engine (requester 1), in front of the shared buffer RAM.

Parameters:
- DW, 16, data width of RAM words and requester data.
- WL, 1024, RAM depth in words; word addresses at or above WL are out of range.

Ports:
- CLK  input  1  clock; all logic on rising edge
- RSTn  input  1  synchronous active-low reset
- req_valid  input  2  per-requester access request; bit i = requester i
- req_ready  output  2  per-requester grant/accept, one-hot or zero
- req_we  input  2  per-requester 1 = write, 0 = read
- req_addr  input  2x13  per-requester byte address; bits [1:0] ignored
- req_wdata  input  2xDW  per-requester write data
- rsp_valid  output  2  per-requester read-response strobe
- rsp_rdata  output  DW  read data, valid only with rsp_valid
- rsp_err  output  1  with rsp_valid: read was out of range
- ram_EN  output  1  to RAM EN
- ram_WE  output  4  to RAM WE
- ram_A  output  13  to RAM A
- ram_Di  output  DW  to RAM Di
- ram_Do  input  DW  from RAM Do

Behaviour:
Reset:
- Reset is synchronous and active-low.
- Outputs after reset: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, ram_EN=0, ram_WE=0, ram_A=0, ram_Di=0.
- Round-robin pointer resets to "last served = 1", so requester 0 wins the first contention.
- Reset mid-operation drops any pending read response; no rsp_valid is issued for it.

Arbitration (combinational from req_valid and the registered pointer):
- One valid requester: granted the same cycle.
- Both valid: grant goes to the requester not last served.
- Pointer updates only on a grant; an idle cycle leaves it unchanged.
- Exactly one access per cycle; throughput 1 access/cycle; a requester may be granted on consecutive cycles when the other is idle.

Handshake:
- Transfer occurs when req_valid[i] & req_ready[i].
- A requester holds valid, we, addr and wdata stable until ready.
- The arbiter never withdraws ready for a valid requester within the granted cycle.

RAM drive:
- ram_A = granted req_addr; ram_Di = granted req_wdata.
- ram_WE = 4'hF for a granted in-range write, else 4'h0.
- ram_EN = 1 when an in-range access is granted OR a read response is pending this cycle.
  - The RAM gates Do with the current EN, so EN must be high in the response cycle.
  - A response-cycle EN with WE=0 is a no-op.
- ram_A when idle holds its last value (no functional effect).

Range check:
- Word index = req_addr>>2. Index >= WL is out of range.
- Out-of-range write: accepted (ready=1), no RAM write, silently dropped.
- Out-of-range read: accepted; ram_EN not asserted for the access; response carries rsp_rdata=0, rsp_err=1.

Response pipeline:
- The registers pend_valid, pend_owner and pend_err capture a granted read at the clock edge.
- In the next cycle: rsp_valid[pend_owner]=1, rsp_rdata=ram_Do (0 if pend_err), rsp_err=pend_err.
- Latency: grant in cycle T -> response in T+1.
- Writes produce no response.
- Read-after-write to the same address in the next cycle returns the new data.
- A response cycle and a new grant may coincide; both proceed.

Test Plan:
- Reset then idle: all outputs 0 and ram_EN=0 for 5 cycles; deassert RSTn mid-read (grant at T, RSTn low at T+1) -> no rsp_valid.
- Requester 0 writes 0xA5A5 to byte address 0x010, then reads 0x010 -> ram_WE=4'hF on the write cycle; rsp_valid[0] exactly 1 cycle after the read grant with rsp_rdata=0xA5A5 and ram_EN=1 in that response cycle.
- Both requesters hold reads continuously (req0 addr 0x000 = 0x1111, req1 addr 0x004 = 0x2222) -> grants alternate 0,1,0,1; responses alternate with the correct owner and data; no bubble cycles.
- Requester 1 alone issues 4 back-to-back reads of addresses 0x0, 0x4, 0x8, 0xC -> ready every cycle; 4 consecutive rsp_valid[1] in order.
- Out-of-range: write 0x1234 to 0x1000 (word 1024), then read 0x1000 -> no RAM write (word 0 unchanged); read response rsp_rdata=0, rsp_err=1.
- Requester 0 writes 0xBEEF to 0x020 while requester 1 reads 0x020 in the same cycle, pointer last-served=1 -> write granted first; read granted next cycle and returns 0xBEEF.
